sram_axi_bridge: RTL and testbench

SRAM_AXI_BRIDGE -- requirements
Module: sram_axi_bridge

---
 rtl/sram_axi_bridge_pkg.sv | 26 ++
 rtl/sram_axi_bridge.sv | 226 ++++++++++++++++++++++
 tb/tb_sram_axi_bridge.sv | 452 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/sram_axi_bridge_pkg.sv
// Shared types and fixed AXI encodings for the SRAM-like to AXI bridge.
package sram_axi_bridge_pkg;

    typedef enum logic [1:0] {
        R_IDLE = 2'd0,
        R_AR   = 2'd1,
        R_R    = 2'd2
    } r_state_e;

    typedef enum logic [1:0] {
        W_IDLE = 2'd0,
        W_REQ  = 2'd1,
        W_B    = 2'd2
    } w_state_e;

    typedef enum logic {
        OWNER_INST = 1'b0,
        OWNER_DATA = 1'b1
    } owner_e;

    localparam logic [7:0] AXI_LEN_SINGLE = 8'd0;
    localparam logic [1:0] AXI_BURST_INCR = 2'b01;
    localparam logic [2:0] AXI_SIZE_WORD  = 3'd2;
    localparam logic [3:0] AXI_WRITE_ID   = 4'd1;

endpackage

// File: rtl/sram_axi_bridge.sv
// Bridges a CPU instruction port and data port (SRAM-like addr_ok/data_ok
// handshake) onto a single AXI master with one read and one write in flight.
module sram_axi_bridge
    import sram_axi_bridge_pkg::*;
#(
    parameter logic [3:0] INST_ARID = 4'd0,
    parameter logic [3:0] DATA_ARID = 4'd1
) (
    input  logic        clk,
    input  logic        reset,

    input  logic        inst_req,
    input  logic [31:0] inst_addr,
    output logic [31:0] inst_rdata,
    output logic        inst_addr_ok,
    output logic        inst_data_ok,

    input  logic        data_req,
    input  logic        data_wr,
    input  logic [3:0]  data_wstrb,
    input  logic [31:0] data_addr,
    input  logic [2:0]  data_size,
    input  logic [31:0] data_wdata,
    output logic [31:0] data_rdata,
    output logic        data_addr_ok,
    output logic        data_data_ok,

    output logic [3:0]  arid,
    output logic [31:0] araddr,
    output logic [7:0]  arlen,
    output logic [2:0]  arsize,
    output logic [1:0]  arburst,
    output logic        arvalid,
    input  logic        arready,

    input  logic [3:0]  rid,
    input  logic [31:0] rdata,
    input  logic [1:0]  rresp,
    input  logic        rlast,
    input  logic        rvalid,
    output logic        rready,

    output logic [3:0]  awid,
    output logic [31:0] awaddr,
    output logic [7:0]  awlen,
    output logic [2:0]  awsize,
    output logic [1:0]  awburst,
    output logic        awvalid,
    input  logic        awready,

    output logic [3:0]  wid,
    output logic [31:0] wdata,
    output logic [3:0]  wstrb,
    output logic        wlast,
    output logic        wvalid,
    input  logic        wready,

    input  logic [3:0]  bid,
    input  logic [1:0]  bresp,
    input  logic        bvalid,
    output logic        bready
);

    r_state_e    r_state_q, r_state_d;
    owner_e      r_owner_q, r_owner_d;
    logic [31:0] r_addr_q, r_addr_d;
    logic [2:0]  r_size_q, r_size_d;

    w_state_e    w_state_q, w_state_d;
    logic        aw_pend_q, aw_pend_d;
    logic        w_pend_q, w_pend_d;
    logic [31:0] w_addr_q, w_addr_d;
    logic [31:0] w_data_q, w_data_d;
    logic [2:0]  w_size_q, w_size_d;
    logic [3:0]  w_strb_q, w_strb_d;

    logic data_busy;
    logic data_accept;
    logic data_rd_accept;
    logic data_wr_accept;
    logic inst_accept;
    logic r_done;
    logic w_done;
    logic unused_inputs;

    // Response ids/codes are not used: routing relies on the latched owner.
    assign unused_inputs = ^{rid, rresp, rlast, bid, bresp};

    assign data_busy      = ((r_state_q != R_IDLE) && (r_owner_q == OWNER_DATA))
                            || (w_state_q != W_IDLE);
    assign data_accept    = !reset && data_req && !data_busy
                            && (data_wr ? (w_state_q == W_IDLE) : (r_state_q == R_IDLE));
    assign data_rd_accept = data_accept && !data_wr;
    assign data_wr_accept = data_accept && data_wr;
    assign inst_accept    = !reset && inst_req && (r_state_q == R_IDLE) && !data_rd_accept;
    assign r_done         = (r_state_q == R_R) && rvalid;
    assign w_done         = (w_state_q == W_B) && bvalid;

    always_comb begin
        r_state_d = r_state_q;
        r_owner_d = r_owner_q;
        r_addr_d  = r_addr_q;
        r_size_d  = r_size_q;
        case (r_state_q)
            R_IDLE: begin
                if (data_rd_accept) begin
                    r_state_d = R_AR;
                    r_owner_d = OWNER_DATA;
                    r_addr_d  = data_addr;
                    r_size_d  = data_size;
                end else if (inst_accept) begin
                    r_state_d = R_AR;
                    r_owner_d = OWNER_INST;
                    r_addr_d  = inst_addr;
                    r_size_d  = AXI_SIZE_WORD;
                end
            end
            R_AR: begin
                if (arready) begin
                    r_state_d = R_R;
                end
            end
            R_R: begin
                if (rvalid) begin
                    r_state_d = R_IDLE;
                end
            end
            default: r_state_d = R_IDLE;
        endcase
    end

    // Address and data channels retire independently; B waits for both.
    always_comb begin
        w_state_d = w_state_q;
        aw_pend_d = aw_pend_q;
        w_pend_d  = w_pend_q;
        w_addr_d  = w_addr_q;
        w_data_d  = w_data_q;
        w_size_d  = w_size_q;
        w_strb_d  = w_strb_q;
        case (w_state_q)
            W_IDLE: begin
                if (data_wr_accept) begin
                    w_state_d = W_REQ;
                    aw_pend_d = 1'b1;
                    w_pend_d  = 1'b1;
                    w_addr_d  = data_addr;
                    w_data_d  = data_wdata;
                    w_size_d  = data_size;
                    w_strb_d  = data_wstrb;
                end
            end
            W_REQ: begin
                aw_pend_d = aw_pend_q && !awready;
                w_pend_d  = w_pend_q && !wready;
                if (!aw_pend_d && !w_pend_d) begin
                    w_state_d = W_B;
                end
            end
            W_B: begin
                if (bvalid) begin
                    w_state_d = W_IDLE;
                end
            end
            default: w_state_d = W_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state_q <= R_IDLE;
            r_owner_q <= OWNER_INST;
            r_addr_q  <= 32'd0;
            r_size_q  <= 3'd0;
            w_state_q <= W_IDLE;
            aw_pend_q <= 1'b0;
            w_pend_q  <= 1'b0;
            w_addr_q  <= 32'd0;
            w_data_q  <= 32'd0;
            w_size_q  <= 3'd0;
            w_strb_q  <= 4'd0;
        end else begin
            r_state_q <= r_state_d;
            r_owner_q <= r_owner_d;
            r_addr_q  <= r_addr_d;
            r_size_q  <= r_size_d;
            w_state_q <= w_state_d;
            aw_pend_q <= aw_pend_d;
            w_pend_q  <= w_pend_d;
            w_addr_q  <= w_addr_d;
            w_data_q  <= w_data_d;
            w_size_q  <= w_size_d;
            w_strb_q  <= w_strb_d;
        end
    end

    assign inst_addr_ok = inst_accept;
    assign data_addr_ok = data_accept;
    assign inst_data_ok = !reset && r_done && (r_owner_q == OWNER_INST);
    assign data_data_ok = !reset && ((r_done && (r_owner_q == OWNER_DATA)) || w_done);
    assign inst_rdata   = rdata;
    assign data_rdata   = rdata;

    assign arid    = (r_owner_q == OWNER_INST) ? INST_ARID : DATA_ARID;
    assign araddr  = r_addr_q;
    assign arlen   = AXI_LEN_SINGLE;
    assign arsize  = r_size_q;
    assign arburst = AXI_BURST_INCR;
    assign arvalid = !reset && (r_state_q == R_AR);
    assign rready  = !reset && (r_state_q == R_R);

    assign awid    = AXI_WRITE_ID;
    assign awaddr  = w_addr_q;
    assign awlen   = AXI_LEN_SINGLE;
    assign awsize  = w_size_q;
    assign awburst = AXI_BURST_INCR;
    assign awvalid = !reset && (w_state_q == W_REQ) && aw_pend_q;

    assign wid     = AXI_WRITE_ID;
    assign wdata   = w_data_q;
    assign wstrb   = w_strb_q;
    assign wlast   = 1'b1;
    assign wvalid  = !reset && (w_state_q == W_REQ) && w_pend_q;
    assign bready  = !reset && (w_state_q == W_B);

endmodule

// File: tb/tb_sram_axi_bridge.sv
// Scoreboard bench: random CPU traffic and a random-latency AXI slave, with
// expectations queued at request acceptance and checked by monitors.
module tb_sram_axi_bridge;

    logic        clk = 1'b0;
    logic        reset;
    logic        inst_req;
    logic [31:0] inst_addr;
    logic [31:0] inst_rdata;
    logic        inst_addr_ok, inst_data_ok;
    logic        data_req, data_wr;
    logic [3:0]  data_wstrb;
    logic [31:0] data_addr, data_wdata, data_rdata;
    logic [2:0]  data_size;
    logic        data_addr_ok, data_data_ok;
    logic [3:0]  arid, rid, awid, wid, bid;
    logic [31:0] araddr, rdata, awaddr, wdata;
    logic [7:0]  arlen, awlen;
    logic [2:0]  arsize, awsize;
    logic [1:0]  arburst, awburst, rresp, bresp;
    logic        arvalid, arready, rlast, rvalid, rready;
    logic        awvalid, awready, wlast, wvalid, wready, bvalid, bready;
    logic [3:0]  wstrb;

    sram_axi_bridge dut (
        .clk(clk), .reset(reset),
        .inst_req(inst_req), .inst_addr(inst_addr), .inst_rdata(inst_rdata),
        .inst_addr_ok(inst_addr_ok), .inst_data_ok(inst_data_ok),
        .data_req(data_req), .data_wr(data_wr), .data_wstrb(data_wstrb),
        .data_addr(data_addr), .data_size(data_size), .data_wdata(data_wdata),
        .data_rdata(data_rdata), .data_addr_ok(data_addr_ok), .data_data_ok(data_data_ok),
        .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst),
        .arvalid(arvalid), .arready(arready),
        .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready),
        .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize), .awburst(awburst),
        .awvalid(awvalid), .awready(awready),
        .wid(wid), .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
        .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready)
    );

    always #5 clk = ~clk;

    typedef struct { logic [31:0] addr; logic [3:0] id; logic [2:0] size; } ar_exp_t;
    typedef struct { logic [31:0] addr; logic [2:0] size; } aw_exp_t;
    typedef struct { logic [31:0] data; logic [3:0] strb; } w_exp_t;
    typedef struct { bit is_write; logic [31:0] rdata; } dr_exp_t;

    ar_exp_t     ar_q[$];
    aw_exp_t     aw_q[$];
    w_exp_t      w_q[$];
    dr_exp_t     dr_q[$];
    logic [31:0] inst_q[$];

    logic [31:0] ref_mem[logic [29:0]];
    logic [31:0] slave_mem[logic [29:0]];

    int compared = 0;
    int mismatched = 0;
    bit hold_r = 1'b0;
    bit hold_b = 1'b0;
    bit ordered = 1'b0;

    task automatic check_output(input string name, input logic [63:0] actual, input logic [63:0] expected);
        compared++;
        if (actual !== expected) begin
            mismatched++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, actual, expected, $time);
        end
    endtask

    task automatic report_timeout(input string name);
        compared++;
        mismatched++;
        $display("[TB] FAIL %s: expected event did not occur within its cycle budget (t=%0t)", name, $time);
    endtask

    function automatic logic [31:0] default_word(input logic [31:0] a);
        return {a[31:2], 2'b00} ^ 32'h1357_9BDF;
    endfunction

    function automatic logic [31:0] ref_read(input logic [31:0] a);
        if (ref_mem.exists(a[31:2])) return ref_mem[a[31:2]];
        return default_word(a);
    endfunction

    function automatic logic [31:0] slave_read(input logic [31:0] a);
        if (slave_mem.exists(a[31:2])) return slave_mem[a[31:2]];
        return default_word(a);
    endfunction

    function automatic logic [31:0] merge_bytes(input logic [31:0] old, input logic [31:0] d, input logic [3:0] strb);
        logic [31:0] w = old;
        for (int b = 0; b < 4; b++) begin
            if (strb[b]) w[b*8 +: 8] = d[b*8 +: 8];
        end
        return w;
    endfunction

    function automatic void push_inst(input logic [31:0] a);
        ar_exp_t e;
        e.addr = a; e.id = 4'd0; e.size = 3'd2;
        ar_q.push_back(e);
        inst_q.push_back(ref_read(a));
    endfunction

    function automatic void push_data_read(input logic [31:0] a, input logic [2:0] s);
        ar_exp_t e;
        dr_exp_t d;
        e.addr = a; e.id = 4'd1; e.size = s;
        d.is_write = 1'b0; d.rdata = ref_read(a);
        ar_q.push_back(e);
        dr_q.push_back(d);
    endfunction

    function automatic void push_data_write(input logic [31:0] a, input logic [2:0] s,
                                            input logic [3:0] strb, input logic [31:0] d);
        aw_exp_t ea;
        w_exp_t  ew;
        dr_exp_t ed;
        ea.addr = a; ea.size = s;
        ew.data = d; ew.strb = strb;
        ed.is_write = 1'b1; ed.rdata = 32'd0;
        aw_q.push_back(ea);
        w_q.push_back(ew);
        dr_q.push_back(ed);
        ref_mem[a[31:2]] = merge_bytes(ref_read(a), d, strb);
    endfunction

    // AXI slave with random ready/response latency; also checks every AXI handshake.
    initial begin : axi_slave
        bit rd_busy, aw_got, w_got, b_pend;
        int rd_wait, b_wait;
        logic [31:0] rd_addr, wa, wd;
        logic [3:0] ws;
        ar_exp_t ea;
        aw_exp_t eaw;
        w_exp_t ew;
        rd_busy = 0; aw_got = 0; w_got = 0; b_pend = 0; rd_wait = 0; b_wait = 0;
        rd_addr = 0; wa = 0; wd = 0; ws = 0;
        arready = 0; rvalid = 0; rdata = 0; rid = 0; rresp = 0; rlast = 0;
        awready = 0; wready = 0; bvalid = 0; bid = 0; bresp = 0;
        forever begin
            @(negedge clk);
            arready = !rd_busy && ($urandom_range(0, 2) != 0);
            rvalid  = rd_busy && (rd_wait == 0) && !hold_r;
            rdata   = rvalid ? slave_read(rd_addr) : $urandom;
            rid     = 4'($urandom_range(0, 15));
            rresp   = 2'($urandom_range(0, 3));
            rlast   = 1'($urandom_range(0, 1));
            awready = !aw_got && (ordered || ($urandom_range(0, 2) != 0));
            wready  = !w_got && (ordered ? aw_got : ($urandom_range(0, 2) != 0));
            bvalid  = b_pend && (b_wait == 0) && !hold_b;
            bid     = 4'($urandom_range(0, 15));
            bresp   = 2'($urandom_range(0, 3));
            #1;
            if (reset) begin
                rd_busy = 0; aw_got = 0; w_got = 0; b_pend = 0;
                continue;
            end
            if (rvalid && rready) rd_busy = 0;
            else if (rd_busy && rd_wait > 0) rd_wait--;
            if (arvalid && arready) begin
                if (ar_q.size() == 0) begin
                    report_timeout("ar_without_request");
                end else begin
                    ea = ar_q.pop_front();
                    check_output("araddr", araddr, ea.addr);
                    check_output("arid", arid, ea.id);
                    check_output("arsize", arsize, ea.size);
                    check_output("arlen_arburst", {arlen, arburst}, {8'd0, 2'b01});
                end
                rd_busy = 1; rd_addr = araddr; rd_wait = $urandom_range(0, 3);
            end
            if (bvalid && bready) b_pend = 0;
            else if (b_pend && b_wait > 0) b_wait--;
            if (awvalid && awready) begin
                if (aw_q.size() == 0) begin
                    report_timeout("aw_without_request");
                end else begin
                    eaw = aw_q.pop_front();
                    check_output("awaddr", awaddr, eaw.addr);
                    check_output("awsize", awsize, eaw.size);
                    check_output("awid_awlen_awburst", {awid, awlen, awburst}, {4'd1, 8'd0, 2'b01});
                end
                aw_got = 1; wa = awaddr;
            end
            if (wvalid && wready) begin
                if (w_q.size() == 0) begin
                    report_timeout("w_without_request");
                end else begin
                    ew = w_q.pop_front();
                    check_output("wdata", wdata, ew.data);
                    check_output("wstrb", wstrb, ew.strb);
                    check_output("wid_wlast", {wid, wlast}, {4'd1, 1'b1});
                end
                w_got = 1; wd = wdata; ws = wstrb;
            end
            if (aw_got && w_got) begin
                slave_mem[wa[31:2]] = merge_bytes(slave_read(wa), wd, ws);
                aw_got = 0; w_got = 0; b_pend = 1; b_wait = $urandom_range(0, 3);
            end
        end
    end

    // CPU-side monitor: handshake acceptance model plus in-order response scoreboard.
    initial begin : cpu_monitor
        int rd_out, wr_out, dt_out;
        bit exp_d, exp_i;
        dr_exp_t de;
        rd_out = 0; wr_out = 0; dt_out = 0;
        forever begin
            @(negedge clk);
            #1;
            if (reset) begin
                check_output("reset_outputs",
                    {arvalid, rready, awvalid, wvalid, bready,
                     inst_addr_ok, data_addr_ok, inst_data_ok, data_data_ok}, 64'd0);
                rd_out = 0; wr_out = 0; dt_out = 0;
                ar_q.delete(); aw_q.delete(); w_q.delete(); dr_q.delete(); inst_q.delete();
                continue;
            end
            exp_d = data_req && (dt_out == 0) && (data_wr ? (wr_out == 0) : (rd_out == 0));
            exp_i = inst_req && (rd_out == 0) && !(data_req && !data_wr && exp_d);
            check_output("data_addr_ok", data_addr_ok, exp_d);
            check_output("inst_addr_ok", inst_addr_ok, exp_i);
            if (inst_data_ok) begin
                if (inst_q.size() == 0) begin
                    report_timeout("inst_data_ok_without_request");
                end else begin
                    check_output("inst_rdata", inst_rdata, inst_q.pop_front());
                    rd_out--;
                end
            end
            if (data_data_ok) begin
                if (dr_q.size() == 0) begin
                    report_timeout("data_data_ok_without_request");
                end else begin
                    de = dr_q.pop_front();
                    if (de.is_write) begin
                        wr_out--;
                    end else begin
                        check_output("data_rdata", data_rdata, de.rdata);
                        rd_out--;
                    end
                    dt_out--;
                end
            end
            if (inst_addr_ok) rd_out++;
            if (data_addr_ok) begin
                dt_out++;
                if (data_wr) wr_out++;
                else rd_out++;
            end
        end
    end

    task automatic manual_reads(input bit do_inst, input logic [31:0] ia, input bit do_data,
                                input logic [31:0] da, input logic [2:0] ds,
                                input bit chk_first, input logic [1:0] first_exp);
        bit i_pend, d_pend, first;
        int guard;
        i_pend = do_inst; d_pend = do_data; first = 1'b1; guard = 0;
        @(negedge clk);
        inst_req = do_inst; inst_addr = ia;
        data_req = do_data; data_wr = 1'b0; data_addr = da; data_size = ds; data_wstrb = 4'h0;
        while ((i_pend || d_pend) && guard < 60) begin
            #1;
            if (first && chk_first) check_output("first_cycle_addr_ok", {inst_addr_ok, data_addr_ok}, first_exp);
            first = 1'b0;
            if (i_pend && inst_addr_ok) begin push_inst(ia); i_pend = 1'b0; end
            if (d_pend && data_addr_ok) begin push_data_read(da, ds); d_pend = 1'b0; end
            @(negedge clk);
            if (!i_pend) inst_req = 1'b0;
            if (!d_pend) data_req = 1'b0;
            guard++;
        end
        if (i_pend || d_pend) begin
            report_timeout("manual_read_accept");
            inst_req = 1'b0;
            data_req = 1'b0;
        end
    endtask

    task automatic manual_write(input logic [31:0] a, input logic [3:0] strb, input logic [31:0] d);
        bit accepted, aw_seen;
        int guard;
        accepted = 1'b0; aw_seen = 1'b0; guard = 0;
        @(negedge clk);
        data_req = 1'b1; data_wr = 1'b1; data_addr = a; data_size = 3'd2;
        data_wstrb = strb; data_wdata = d;
        while (!accepted && guard < 60) begin
            #1;
            if (data_addr_ok) begin push_data_write(a, 3'd2, strb, d); accepted = 1'b1; end
            @(negedge clk);
            guard++;
        end
        data_req = 1'b0;
        data_wr = 1'b0;
        if (!accepted) report_timeout("manual_write_accept");
        guard = 0;
        while (accepted && !aw_seen && guard < 20) begin
            #1;
            aw_seen = awvalid && awready;
            @(negedge clk);
            guard++;
        end
        if (accepted && !aw_seen) report_timeout("manual_write_aw");
        if (aw_seen) begin
            #1;
            check_output("aw_done_w_held", {awvalid, wvalid}, 2'b01);
        end
    endtask

    task automatic wait_drain(input int budget, input string name);
        int c;
        bit empty;
        c = 0;
        empty = 1'b0;
        while (!empty && c < budget) begin
            @(negedge clk);
            #2;
            empty = (ar_q.size() == 0) && (aw_q.size() == 0) && (w_q.size() == 0)
                    && (dr_q.size() == 0) && (inst_q.size() == 0);
            c++;
        end
        if (!empty) report_timeout(name);
    endtask

    task automatic random_inst_driver(input int cycles);
        bit acc;
        int c;
        acc = 1'b0; c = 0;
        while ((c < cycles || inst_req) && c < cycles + 200) begin
            @(negedge clk);
            c++;
            if (acc) begin inst_req = 1'b0; acc = 1'b0; end
            if (c < cycles && !inst_req && $urandom_range(0, 2) == 0) begin
                inst_req = 1'b1;
                inst_addr = 32'hBFC0_0000 + ($urandom_range(0, 63) << 2);
            end
            #1;
            if (inst_req && !acc && inst_addr_ok) begin push_inst(inst_addr); acc = 1'b1; end
        end
        if (inst_req) begin report_timeout("random_inst_accept"); inst_req = 1'b0; end
    endtask

    task automatic random_data_driver(input int cycles);
        bit acc;
        int c, off;
        logic [2:0] sz;
        acc = 1'b0; c = 0;
        while ((c < cycles || data_req) && c < cycles + 200) begin
            @(negedge clk);
            c++;
            if (acc) begin data_req = 1'b0; acc = 1'b0; end
            if (c < cycles && !data_req && $urandom_range(0, 2) == 0) begin
                sz  = 3'($urandom_range(0, 2));
                off = (sz == 3'd0) ? $urandom_range(0, 3) : (sz == 3'd1) ? 2 * $urandom_range(0, 1) : 0;
                data_req   = 1'b1;
                data_wr    = 1'($urandom_range(0, 1));
                data_size  = sz;
                data_addr  = 32'h8000_0000 + ($urandom_range(0, 31) << 2) + off;
                data_wdata = $urandom;
                data_wstrb = (sz == 3'd0) ? (4'b0001 << off) : (sz == 3'd1) ? (4'b0011 << off) : 4'hF;
            end
            #1;
            if (data_req && !acc && data_addr_ok) begin
                if (data_wr) push_data_write(data_addr, data_size, data_wstrb, data_wdata);
                else push_data_read(data_addr, data_size);
                acc = 1'b1;
            end
        end
        if (data_req) begin report_timeout("random_data_accept"); data_req = 1'b0; end
    endtask

    initial begin : main
        logic [31:0] boot_addr;
        int guard;
        boot_addr = 32'hBFC0_0000;
        ref_mem[boot_addr[31:2]]   = 32'h3C1D_0001;
        slave_mem[boot_addr[31:2]] = 32'h3C1D_0001;
        reset = 1'b1;
        inst_req = 1'b0; inst_addr = 32'd0;
        data_req = 1'b0; data_wr = 1'b0; data_wstrb = 4'd0;
        data_addr = 32'd0; data_size = 3'd0; data_wdata = 32'd0;
        repeat (3) @(negedge clk);
        reset = 1'b0;

        $display("[TB] boot instruction fetch");
        manual_reads(1'b1, 32'hBFC0_0000, 1'b0, 32'd0, 3'd0, 1'b1, 2'b10);
        wait_drain(50, "boot_fetch_drain");

        $display("[TB] simultaneous instruction and data read");
        manual_reads(1'b1, 32'hBFC0_0004, 1'b1, 32'h8000_1000, 3'd2, 1'b1, 2'b01);
        wait_drain(80, "priority_drain");

        $display("[TB] store with AW before W, then blocked data read");
        hold_b = 1'b1;
        ordered = 1'b1;
        manual_write(32'h8000_2004, 4'hF, 32'hCAFE_F00D);
        fork
            manual_reads(1'b1, 32'hBFC0_0008, 1'b1, 32'h8000_2004, 3'd2, 1'b1, 2'b10);
            begin
                repeat (10) @(negedge clk);
                hold_b = 1'b0;
            end
        join
        ordered = 1'b0;
        wait_drain(80, "write_block_drain");

        $display("[TB] random traffic");
        fork
            random_inst_driver(3000);
            random_data_driver(3000);
        join
        wait_drain(300, "random_drain");

        $display("[TB] reset during read data phase");
        hold_r = 1'b1;
        manual_reads(1'b1, 32'hBFC0_0010, 1'b0, 32'd0, 3'd0, 1'b0, 2'b00);
        guard = 0;
        while (guard < 20) begin
            #1;
            if (rready) break;
            @(negedge clk);
            guard++;
        end
        if (!rready) report_timeout("reach_read_data_phase");
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        #1;
        check_output("post_reset_idle", {arvalid, rready, inst_data_ok, data_data_ok}, 4'd0);
        hold_r = 1'b0;
        repeat (2) @(negedge clk);
        manual_reads(1'b1, 32'hBFC0_0000, 1'b0, 32'd0, 3'd0, 1'b1, 2'b10);
        wait_drain(50, "post_reset_fetch_drain");

        repeat (3) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

    initial begin : watchdog
        #500000;
        report_timeout("global_watchdog");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
